pll_enable_sequencer: RTL

- Control stage directly upstream of the PLL primitive, clocked by the same free-running reference clock that feeds the PLL's CLK_IN.
- Drives the PLL's PLL_EN and consumes its LOCK.
- Sequences startup and applies a lock timeout, retrying with a PLL_EN-low off period between attempts.
- Qualifies lock as stable before asserting READY to downstream clock consumers; handles lock loss by re-sequencing and raises FAIL after exhausting retries.

---
 rtl/pll_enable_sequencer_if.sv | 26 ++
 rtl/pll_enable_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pll_enable_sequencer_if.sv
// Signal bundle between the PLL enable sequencer and its surroundings:
// the bring-up request and raw PLL lock in, PLL enable and status out.
interface pll_enable_sequencer_if #(
  parameter int MAX_RETRIES = 3
);
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  logic          START;
  logic          LOCK;
  logic          PLL_EN;
  logic          READY;
  logic          FAIL;
  logic [2:0]    STATE;
  logic [RW-1:0] RETRY_CNT;
  logic [7:0]    LOSS_CNT;

  modport master (
    input  START, LOCK,
    output PLL_EN, READY, FAIL, STATE, RETRY_CNT, LOSS_CNT
  );

  modport slave (
    output START, LOCK,
    input  PLL_EN, READY, FAIL, STATE, RETRY_CNT, LOSS_CNT
  );
endinterface

// File: rtl/pll_enable_sequencer.sv
// Brings a PLL up from its reference clock: enable, wait for lock with timeout
// and retries, qualify lock as stable, then report READY; re-sequences on loss.
module pll_enable_sequencer #(
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int STABLE_CYCLES = 16,
  parameter int OFF_CYCLES    = 8,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  pll_enable_sequencer_if.master bus
);
  // Must match the interface's RETRY_CNT width for the same MAX_RETRIES.
  localparam int RW   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int TMAX = (LOCK_TIMEOUT > STABLE_CYCLES)
                        ? ((LOCK_TIMEOUT > OFF_CYCLES) ? LOCK_TIMEOUT : OFF_CYCLES)
                        : ((STABLE_CYCLES > OFF_CYCLES) ? STABLE_CYCLES : OFF_CYCLES);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ENABLE = 3'd1,
    S_STABLE = 3'd2,
    S_READY  = 3'd3,
    S_OFF    = 3'd4,
    S_FAIL   = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          pll_en_q, pll_en_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;
  logic          lock_meta_q, lock_s_q;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so both flops sample pre-edge values and form a real two-stage chain.
      lock_meta_q <= bus.LOCK;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    if (!bus.START) begin
      state_d = S_IDLE;
      retry_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_ENABLE;
          retry_d = '0;
        end
        S_ENABLE: begin
          if (lock_s_q) begin
            state_d = S_STABLE;
          end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
            if (retry_q == RW'(MAX_RETRIES)) begin
              state_d = S_FAIL;
            end else begin
              retry_d = retry_q + RW'(1);
              state_d = S_OFF;
            end
          end
        end
        S_STABLE: begin
          if (!lock_s_q) begin
            state_d = S_ENABLE;
          end else if (timer_q == TW'(STABLE_CYCLES - 1)) begin
            state_d = S_READY;
            retry_d = '0;
          end
        end
        S_READY: begin
          if (!lock_s_q) begin
            state_d = S_OFF;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end
        S_OFF: begin
          if (timer_q == TW'(OFF_CYCLES - 1)) state_d = S_ENABLE;
        end
        S_FAIL:  state_d = S_FAIL;
        default: state_d = S_IDLE;
      endcase
    end

    // One shared timer: zero on any state entry, counts only in timed states.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (state_q == S_ENABLE || state_q == S_STABLE || state_q == S_OFF) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = '0;
    end

    pll_en_d = (state_d == S_ENABLE) || (state_d == S_STABLE) || (state_d == S_READY);
    ready_d  = (state_d == S_READY);
    fail_d   = (state_d == S_FAIL);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      retry_q  <= '0;
      loss_q   <= '0;
      pll_en_q <= 1'b0;
      ready_q  <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      retry_q  <= retry_d;
      loss_q   <= loss_d;
      pll_en_q <= pll_en_d;
      ready_q  <= ready_d;
      fail_q   <= fail_d;
    end
  end

  assign bus.PLL_EN    = pll_en_q;
  assign bus.READY     = ready_q;
  assign bus.FAIL      = fail_q;
  assign bus.STATE     = state_q;
  assign bus.RETRY_CNT = retry_q;
  assign bus.LOSS_CNT  = loss_q;
endmodule
